// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg
// Shared definitions for the commit-point exception controller:
//   - CP0 excepttype codes reported for each exception source
//   - bit positions inside exc_flags_i
//   - FSM state encoding and bad-address source select
//   - default exception vector
package exception_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    // Codes handed to CP0
    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_ADEL = 32'h04;
    localparam logic [31:0] EXC_ADES = 32'h05;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_BP   = 32'h09;
    localparam logic [31:0] EXC_RI   = 32'h0a;
    localparam logic [31:0] EXC_OV   = 32'h0c;
    localparam logic [31:0] EXC_TR   = 32'h0d;
    localparam logic [31:0] EXC_ERET = 32'h0e;

    // exc_flags_i bit indices
    localparam int F_ADEL_FETCH = 0;
    localparam int F_RI         = 1;
    localparam int F_OV         = 2;
    localparam int F_TR         = 3;
    localparam int F_SYS        = 4;
    localparam int F_BP         = 5;
    localparam int F_ADEL_LOAD  = 6;
    localparam int F_ADES       = 7;
    localparam int F_ERET       = 8;
    localparam int NUM_FLAGS    = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } exc_state_e;

    // Which address (if any) becomes BadVAddr
    typedef enum logic [1:0] {
        BAD_NONE  = 2'd0,
        BAD_FETCH = 2'd1,
        BAD_DATA  = 2'd2
    } bad_sel_e;

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// exception_ctrl_prio_enc (module exc_prio_enc)
// Combinational priority resolution of one instruction's exception sources.
// Ports:
//   int_pend  in   interrupt pending (already masked by Status)
//   flags     in   exc_flags_i vector
//   valid     out  some source is active
//   code      out  excepttype code of the winning source
//   bad_sel   out  which address feeds BadVAddr for the winner
module exc_prio_enc
    import exception_ctrl_pkg::*;
(
    input  logic                 int_pend,
    input  logic [NUM_FLAGS-1:0] flags,
    output logic                 valid,
    output logic [31:0]          code,
    output bad_sel_e             bad_sel
);

    always_comb begin
        valid   = int_pend | (|flags);
        code    = '0;
        bad_sel = BAD_NONE;
        // Interrupt first; eret last so any real exception overrides it.
        if (int_pend)                       code = EXC_INT;
        else if (flags[F_ADEL_FETCH]) begin code = EXC_ADEL; bad_sel = BAD_FETCH; end
        else if (flags[F_RI])               code = EXC_RI;
        else if (flags[F_OV])               code = EXC_OV;
        else if (flags[F_TR])               code = EXC_TR;
        else if (flags[F_SYS])              code = EXC_SYS;
        else if (flags[F_BP])               code = EXC_BP;
        else if (flags[F_ADEL_LOAD]) begin  code = EXC_ADEL; bad_sel = BAD_DATA; end
        else if (flags[F_ADES]) begin       code = EXC_ADES; bad_sel = BAD_DATA; end
        else if (flags[F_ERET])             code = EXC_ERET;
    end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl
// Commit-point exception/interrupt controller in the MEM stage. Picks the
// highest-priority event of a valid instruction, reports it to CP0 for one
// cycle, holds flush for FLUSH_CYCLES cycles, then offers the redirect PC to
// fetch until it is accepted.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_valid_i/pc/in_delayslot   MEM-stage instruction info
//   exc_flags_i                   per-instruction exception flags
//   fetch/data_badaddr_i          candidate BadVAddr values
//   cp0_status/cause/epc_i        current CP0 state
//   excepttype_o, except_pc_o,
//   except_delayslot_o, bad_addr_o   event report to CP0
//   flush_o, busy_o               pipeline flush / MEM freeze
//   redirect_valid_o/pc_o, redirect_ready_i   redirect handshake to fetch
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid_i,
    input  logic [31:0]          mem_pc_i,
    input  logic                 mem_in_delayslot_i,
    input  logic [NUM_FLAGS-1:0] exc_flags_i,
    input  logic [31:0]          fetch_badaddr_i,
    input  logic [31:0]          data_badaddr_i,
    input  logic [31:0]          cp0_status_i,
    input  logic [31:0]          cp0_cause_i,
    input  logic [31:0]          cp0_epc_i,
    output logic [31:0]          excepttype_o,
    output logic [31:0]          except_pc_o,
    output logic                 except_delayslot_o,
    output logic [31:0]          bad_addr_o,
    output logic                 flush_o,
    output logic                 busy_o,
    output logic                 redirect_valid_o,
    output logic [31:0]          redirect_pc_o,
    input  logic                 redirect_ready_i
);

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    exc_state_e  state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] code_q, pc_q, bad_q, tgt_q;
    logic        ds_q;

    logic        int_pend;
    logic        enc_valid;
    logic [31:0] enc_code;
    bad_sel_e    enc_bad_sel;
    logic        detect;
    logic        unused_cp0;

    // IE=1, EXL=0, and at least one enabled pending line
    assign int_pend = cp0_status_i[0] & ~cp0_status_i[1]
                    & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));
    assign unused_cp0 = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                          cp0_cause_i[31:16], cp0_cause_i[7:0]};

    exc_prio_enc u_prio (
        .int_pend (int_pend),
        .flags    (exc_flags_i),
        .valid    (enc_valid),
        .code     (enc_code),
        .bad_sel  (enc_bad_sel)
    );

    assign detect = (state == ST_IDLE) & mem_valid_i & enc_valid;

    // Event capture
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            pc_q   <= '0;
            ds_q   <= 1'b0;
            bad_q  <= '0;
            tgt_q  <= '0;
        end else if (detect) begin
            code_q <= enc_code;
            pc_q   <= mem_pc_i;
            ds_q   <= mem_in_delayslot_i;
            case (enc_bad_sel)
                BAD_FETCH: bad_q <= fetch_badaddr_i;
                BAD_DATA:  bad_q <= data_badaddr_i;
                default:   bad_q <= '0;
            endcase
            tgt_q  <= (enc_code == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
        end
    end

    // Flush counter: loaded on detect, so COMMIT sees FLUSH_CYCLES-1; each
    // COMMIT/FLUSH cycle with a non-zero count consumes one more flush cycle.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (detect)
            cnt <= CNT_INIT;
        else if ((state == ST_COMMIT || state == ST_FLUSH) && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (detect) state_nxt = ST_COMMIT;
            ST_COMMIT:   state_nxt = (cnt != 4'd0) ? ST_FLUSH : ST_REDIRECT;
            ST_FLUSH:    if (cnt == 4'd0) state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready_i) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign excepttype_o       = (state == ST_COMMIT) ? code_q : '0;
    assign except_pc_o        = pc_q;
    assign except_delayslot_o = ds_q;
    assign bad_addr_o         = bad_q;
    assign flush_o            = (state != ST_IDLE);
    assign busy_o             = (state != ST_IDLE);
    assign redirect_valid_o   = (state == ST_REDIRECT);
    assign redirect_pc_o      = tgt_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl
// Directed checks of exception_ctrl. u_d1 uses FLUSH_CYCLES=1, u_d3 uses
// FLUSH_CYCLES=3; both share the data inputs but have their own reset,
// mem_valid and redirect_ready so they can be driven independently.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic [31:0] pc = '0, fbad = '0, dbad = '0, status = '0, cause = '0, epc = '0;
    logic        ds = 1'b0;
    logic [8:0]  flg = '0;
    logic        rst1 = 1'b1, mv1 = 1'b0, rdy1 = 1'b0;
    logic        rst3 = 1'b1, mv3 = 1'b0, rdy3 = 1'b0;

    logic [31:0] exc1, epc1, bad1, rpc1, exc3, epc3, bad3, rpc3;
    logic        ds1, fl1, bz1, rv1, ds3, fl3, bz3, rv3;

    int n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    exception_ctrl #(.FLUSH_CYCLES(1)) u_d1 (
        .clk(clk), .rst(rst1), .mem_valid_i(mv1), .mem_pc_i(pc),
        .mem_in_delayslot_i(ds), .exc_flags_i(flg), .fetch_badaddr_i(fbad),
        .data_badaddr_i(dbad), .cp0_status_i(status), .cp0_cause_i(cause),
        .cp0_epc_i(epc), .excepttype_o(exc1), .except_pc_o(epc1),
        .except_delayslot_o(ds1), .bad_addr_o(bad1), .flush_o(fl1),
        .busy_o(bz1), .redirect_valid_o(rv1), .redirect_pc_o(rpc1),
        .redirect_ready_i(rdy1)
    );

    exception_ctrl #(.FLUSH_CYCLES(3)) u_d3 (
        .clk(clk), .rst(rst3), .mem_valid_i(mv3), .mem_pc_i(pc),
        .mem_in_delayslot_i(ds), .exc_flags_i(flg), .fetch_badaddr_i(fbad),
        .data_badaddr_i(dbad), .cp0_status_i(status), .cp0_cause_i(cause),
        .cp0_epc_i(epc), .excepttype_o(exc3), .except_pc_o(epc3),
        .except_delayslot_o(ds3), .bad_addr_o(bad3), .flush_o(fl3),
        .busy_o(bz3), .redirect_valid_o(rv3), .redirect_pc_o(rpc3),
        .redirect_ready_i(rdy3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full event on u_d1 with redirect_ready held high.
    task automatic ev1(input string tag, input logic [31:0] ipc, input logic ids,
                       input logic [8:0] iflg, input logic [31:0] code,
                       input logic chk_bad, input logic [31:0] bad,
                       input logic [31:0] tgt);
        pc = ipc; ds = ids; flg = iflg; mv1 = 1'b1; rdy1 = 1'b1;
        chk({tag, ".idle_busy"}, 32'(bz1), 32'd0);
        tick();                                   // N+1: commit
        mv1 = 1'b0; flg = '0;
        chk({tag, ".code"}, exc1, code);
        chk({tag, ".pc"}, epc1, ipc);
        chk({tag, ".ds"}, 32'(ds1), 32'(ids));
        if (chk_bad) chk({tag, ".bad"}, bad1, bad);
        chk({tag, ".c_flush"}, 32'(fl1), 32'd1);
        chk({tag, ".c_rv"}, 32'(rv1), 32'd0);
        tick();                                   // N+2: redirect accepted
        chk({tag, ".r_code"}, exc1, 32'd0);
        chk({tag, ".r_rv"}, 32'(rv1), 32'd1);
        chk({tag, ".r_pc"}, rpc1, tgt);
        chk({tag, ".r_flush"}, 32'(fl1), 32'd1);
        tick();                                   // N+3: idle
        chk({tag, ".i_busy"}, 32'(bz1), 32'd0);
        chk({tag, ".i_flush"}, 32'(fl1), 32'd0);
        chk({tag, ".i_rv"}, 32'(rv1), 32'd0);
        rdy1 = 1'b0; ds = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst.exc", exc1, 32'd0);
        chk("rst.pc", epc1, 32'd0);
        chk("rst.bad", bad1, 32'd0);
        chk("rst.rpc", rpc1, 32'd0);
        chk("rst.ctl", {29'd0, fl1, bz1, rv1}, 32'd0);
        chk("rst.ds", 32'(ds1), 32'd0);
        rst1 = 1'b0; rst3 = 1'b0;
        tick();

        ev1("sys", 32'hBFC00100, 1'b0, 9'h010, 32'h08, 1'b0, 32'd0, 32'hBFC00380);

        status = 32'h0000FF01; cause = 32'h00000400;
        ev1("int_ov", 32'h80001000, 1'b1, 9'h004, 32'h01, 1'b0, 32'd0, 32'hBFC00380);

        status = 32'h0000FF03; dbad = 32'h80000003;
        ev1("ades_exl", 32'h80001100, 1'b0, 9'h080, 32'h05, 1'b1, 32'h80000003, 32'hBFC00380);
        status = '0; cause = '0;

        fbad = 32'hBFC00123;
        ev1("adel_f", 32'hBFC00123, 1'b0, 9'h041, 32'h04, 1'b1, 32'hBFC00123, 32'hBFC00380);
        ev1("adel_l", 32'h80001200, 1'b0, 9'h040, 32'h04, 1'b1, 32'h80000003, 32'hBFC00380);
        ev1("ri_ov", 32'h80001300, 1'b0, 9'h006, 32'h0a, 1'b0, 32'd0, 32'hBFC00380);
        ev1("tr_sys", 32'h80001400, 1'b0, 9'h018, 32'h0d, 1'b0, 32'd0, 32'hBFC00380);

        epc = 32'h80002000;
        ev1("eret", 32'h80001500, 1'b0, 9'h100, 32'h0e, 1'b0, 32'd0, 32'h80002000);
        ev1("eret_bp", 32'h80001600, 1'b0, 9'h120, 32'h09, 1'b0, 32'd0, 32'hBFC00380);

        // Flags without mem_valid are not sampled
        flg = 9'h010; mv1 = 1'b0;
        tick();
        chk("nv.busy", 32'(bz1), 32'd0);
        chk("nv.exc", exc1, 32'd0);
        flg = '0;

        // FLUSH_CYCLES=3 with 5+ cycles of backpressure
        pc = 32'h80003000; flg = 9'h010; mv3 = 1'b1; rdy3 = 1'b0;
        tick();                                   // N+1
        chk("bp.c_code", exc3, 32'h08);
        chk("bp.c_flush", 32'(fl3), 32'd1);
        chk("bp.c_rv", 32'(rv3), 32'd0);
        flg = 9'h004;                             // second event while busy
        for (int i = 2; i <= 3; i++) begin
            tick();
            chk($sformatf("bp.f%0d_flush", i), 32'(fl3), 32'd1);
            chk($sformatf("bp.f%0d_rv", i), 32'(rv3), 32'd0);
            chk($sformatf("bp.f%0d_code", i), exc3, 32'd0);
        end
        for (int i = 4; i <= 9; i++) begin
            tick();
            chk($sformatf("bp.r%0d_rv", i), 32'(rv3), 32'd1);
            chk($sformatf("bp.r%0d_flush", i), 32'(fl3), 32'd1);
            chk($sformatf("bp.r%0d_pc", i), rpc3, 32'hBFC00380);
        end
        rdy3 = 1'b1; mv3 = 1'b0;                  // handshake in N+9
        tick();
        chk("bp.i_busy", 32'(bz3), 32'd0);
        chk("bp.i_flush", 32'(fl3), 32'd0);
        chk("bp.i_rv", 32'(rv3), 32'd0);
        rdy3 = 1'b0; flg = '0;
        tick();
        chk("bp.no_second", 32'(bz3), 32'd0);

        // Reset while in REDIRECT
        pc = 32'h80004000; ds = 1'b1; flg = 9'h020; mv3 = 1'b1;
        tick();
        mv3 = 1'b0; flg = '0; ds = 1'b0;
        tick(); tick(); tick();
        chk("mr.rv_before", 32'(rv3), 32'd1);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        chk("mr.exc", exc3, 32'd0);
        chk("mr.pc", epc3, 32'd0);
        chk("mr.bad", bad3, 32'd0);
        chk("mr.rpc", rpc3, 32'd0);
        chk("mr.ctl", {28'd0, ds3, fl3, bz3, rv3}, 32'd0);
        tick();
        pc = 32'h80005000; flg = 9'h010; mv3 = 1'b1;
        tick();
        mv3 = 1'b0; flg = '0; rdy3 = 1'b1;
        chk("mr.new_code", exc3, 32'h08);
        chk("mr.new_pc", epc3, 32'h80005000);
        tick(); tick(); tick();
        chk("mr.new_rv", 32'(rv3), 32'd1);
        tick();
        chk("mr.new_idle", 32'(bz3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Commit-point exception/interrupt controller sitting at the MEM stage, directly upstream of the CP0 register block.
- Collects per-instruction exception flags and pending interrupts, then resolves priority.
- Issues exactly one single-cycle excepttype code to CP0 per event.
- Sequences pipeline flush and PC redirect (exception vector, or EPC for eret) through a ready/valid handshake with the fetch unit.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt.
- FLUSH_CYCLES, 1, cycles flush_o is held before redirect is offered (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- mem_valid_i  in  1  MEM stage holds a real instruction this cycle.
- mem_pc_i  in  32  PC of MEM-stage instruction.
- mem_in_delayslot_i  in  1  instruction is in a branch delay slot.
- exc_flags_i  in  9  one-hot-or-more: [0]AdEL-fetch [1]RI [2]Ov [3]Tr [4]Sys [5]Bp [6]AdEL-load [7]AdES [8]eret.
- fetch_badaddr_i  in  32  faulting fetch address.
- data_badaddr_i  in  32  faulting load/store address.
- cp0_status_i  in  32  current CP0 Status.
- cp0_cause_i  in  32  current CP0 Cause.
- cp0_epc_i  in  32  current CP0 EPC.
- excepttype_o  out  32  code to CP0.
- except_pc_o  out  32  PC to CP0.
- except_delayslot_o  out  1  delay-slot flag to CP0.
- bad_addr_o  out  32  BadVAddr to CP0.
- flush_o  out  1  flush all pipeline stages.
- busy_o  out  1  controller not idle; freezes MEM-stage advance.
- redirect_valid_o  out  1  redirect PC offered to fetch.
- redirect_pc_o  out  32  redirect target.
- redirect_ready_i  in  1  fetch accepts redirect.

Behaviour:
- Reset: all outputs 0 and state IDLE. Reset in any state returns to IDLE next edge and drops any in-flight event.
- Interrupt pending: int_pend = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]).
- Event detect: only in IDLE, when mem_valid_i & (int_pend | |exc_flags_i). Ignored while busy_o=1.
- Priority, highest first. Only the winner is reported.

  | Source | Code |
  |---|---|
  | interrupt | 0x01 |
  | AdEL-fetch | 0x04, bad=fetch_badaddr_i |
  | RI | 0x0a |
  | Ov | 0x0c |
  | Tr | 0x0d |
  | Sys | 0x08 |
  | Bp | 0x09 |
  | AdEL-load | 0x04, bad=data_badaddr_i |
  | AdES | 0x05, bad=data_badaddr_i |
  | eret | 0x0e |

- On detect in cycle N, the following are registered: code, mem_pc_i, delay-slot flag, bad address, and the target. Target is cp0_epc_i for eret, EXC_VECTOR otherwise.
- FSM IDLE -> COMMIT (cycle N+1):
  - excepttype_o = code for exactly this one cycle, with except_pc_o, except_delayslot_o and bad_addr_o valid.
  - flush_o=1, busy_o=1.
  - Flush counter loads FLUSH_CYCLES-1.
- COMMIT -> FLUSH when counter != 0, else -> REDIRECT.
- FLUSH: flush_o=1, excepttype_o=0. Counter decrements each cycle; at 0 -> REDIRECT.
- REDIRECT:
  - redirect_valid_o=1 and redirect_pc_o stable, flush_o=1.
  - Held until redirect_ready_i; on the handshake cycle -> IDLE.
- IDLE: flush_o=0, busy_o=0, redirect_valid_o=0, excepttype_o=0.
- Minimum turnaround with FLUSH_CYCLES=1 and ready high: detect N, commit N+1, redirect accepted N+2, IDLE N+3. Next event can be detected at N+3.
- Simultaneous interrupt and synchronous exception on the same instruction: the interrupt wins and EPC is that instruction's PC.
- eret together with any other flag: the other flag wins.
- mem_valid_i=0: flags and interrupts are not sampled.
- redirect_ready_i high outside REDIRECT is ignored.

Decomposition:
- Shared package/header: excepttype code constants (0x01, 0x04, 0x05, 0x08, 0x09, 0x0a, 0x0c, 0x0d, 0x0e), exc_flags_i bit indices, FSM state encoding, EXC_VECTOR default.
- One natural sub-module, exc_prio_enc: combinational priority encoder producing {valid, code, bad-address select}. The FSM and registers stay in exception_ctrl.

Test Plan:
- Sys only: mem_valid=1, exc_flags=9'h010, pc=0xBFC00100 at N -> excepttype_o=0x08 at N+1 only, except_pc_o=0xBFC00100. With ready=1: redirect_pc_o=0xBFC00380 at N+2, busy_o=0 at N+3.
- Interrupt vs Ov: Status=0x0000FF01, Cause[10]=1, exc_flags=Ov, pc=0x80001000, delayslot=1 -> code 0x01, except_delayslot_o=1, Ov suppressed.
- AdES: data_badaddr=0x80000003 -> code 0x05, bad_addr_o=0x80000003. Also with EXL=1 (Status=0x0000FF03) and Cause[10] set -> no interrupt taken.
- eret: epc=0x80002000 -> code 0x0e, redirect_pc_o=0x80002000. Then eret+Bp together -> code 0x09, target 0xBFC00380.
- Handshake/backpressure: FLUSH_CYCLES=3, redirect_ready=0 for 5 cycles:
  - flush_o high from N+1 through handshake cycle.
  - redirect_valid_o rises at N+4 and is held 5 cycles.
  - A second exception presented while busy is ignored.
- Reset mid-REDIRECT: rst=1 for one cycle -> all outputs 0 next edge. A new Sys afterwards is taken normally.
